// File: rtl/coin_acceptor.sv
// Two-sensor coin acceptor: synchronise and debounce each coin sensor, queue
// confirmed coins in a 4-deep FIFO and hand one money code per cycle downstream.

module coin_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic detect_c
);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    localparam logic [3:0] LAST = 4'(DEBOUNCE - 1);

    state_t     state;
    logic [3:0] count;

    // Fires on the edge that sees the DEBOUNCE-th consecutive high sample
    assign detect_c = (state == CONFIRM) && s && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Start disarmed so a sensor held through reset cannot credit a coin
            state <= RELEASE;
            count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= CONFIRM;
                        count <= 4'd1;
                    end
                end
                CONFIRM: begin
                    if (!s) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else if (count == LAST) begin
                        state <= HELD;
                        count <= 4'd0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE;
                        count <= 4'd1;
                    end
                end
                RELEASE: begin
                    if (s) begin
                        state <= HELD;
                        count <= 4'd0;
                    end else if (count == LAST) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: begin
                    state <= RELEASE;
                    count <= 4'd0;
                end
            endcase
        end
    end

endmodule

module coin_acceptor #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_half,
    input  logic       coin_dollar,
    input  logic       vm_ready,
    output logic [1:0] money,
    output logic [2:0] fifo_count,
    output logic       overflow,
    output logic       reject
);

    localparam logic [1:0] CODE_HALF   = 2'b01;
    localparam logic [1:0] CODE_DOLLAR = 2'b10;
    localparam logic [2:0] DEPTH       = 3'd4;

    logic [1:0] half_sync;
    logic [1:0] dollar_sync;
    logic       half_det_c;
    logic       dollar_det_c;

    logic [1:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    logic       push_c;
    logic       pop_c;
    logic       accept_c;
    logic [1:0] push_code_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            half_sync   <= 2'b00;
            dollar_sync <= 2'b00;
        end else begin
            half_sync   <= {half_sync[0], coin_half};
            dollar_sync <= {dollar_sync[0], coin_dollar};
        end
    end

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_half_db (
        .clk      (clk),
        .rst      (rst),
        .s        (half_sync[1]),
        .detect_c (half_det_c)
    );

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_dollar_db (
        .clk      (clk),
        .rst      (rst),
        .s        (dollar_sync[1]),
        .detect_c (dollar_det_c)
    );

    // Simultaneous detects are ambiguous and credit nothing
    assign push_c      = half_det_c ^ dollar_det_c;
    assign push_code_c = half_det_c ? CODE_HALF : CODE_DOLLAR;
    assign pop_c       = vm_ready && (fifo_count != 3'd0);
    assign accept_c    = push_c && ((fifo_count != DEPTH) || pop_c);

    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_ptr] <= push_code_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            money      <= 2'b00;
            fifo_count <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            overflow   <= 1'b0;
            reject     <= 1'b0;
        end else begin
            money  <= pop_c ? mem[rd_ptr] : 2'b00;
            reject <= half_det_c && dollar_det_c;
            if (pop_c) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (accept_c) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (accept_c && !pop_c) begin
                fifo_count <= fifo_count + 3'd1;
            end else if (pop_c && !accept_c) begin
                fifo_count <= fifo_count - 3'd1;
            end
            if (push_c && !accept_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a run-length/queue model checked every cycle,
// plus literal expectations on the money-code log for each scenario.

module tb_coin_acceptor;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_half = 1'b0;
    logic       coin_dollar = 1'b0;
    logic       vm_ready = 1'b1;
    logic [1:0] money;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       reject;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_half   (coin_half),
        .coin_dollar (coin_dollar),
        .vm_ready    (vm_ready),
        .money       (money),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .reject      (reject)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: sensors seen two edges late; a coin is D consecutive highs while
    // armed, re-arming takes D consecutive lows. Queue holds pending codes.
    bit m_s1 [2];
    bit m_s2 [2];
    bit armed [2];
    int hr [2];
    int lr [2];
    bit m_det [2];
    int q [$];
    int m_money = 0;
    int m_overflow = 0;
    int m_reject = 0;
    bit started = 0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; armed[i] = 0; hr[i] = 0; lr[i] = 0;
            end
            q.delete();
            m_money = 0; m_overflow = 0; m_reject = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_det[i] = 0;
                if (armed[i]) begin
                    if (m_s2[i]) begin
                        hr[i]++;
                        if (hr[i] == D) begin
                            m_det[i] = 1; armed[i] = 0; lr[i] = 0;
                        end
                    end else hr[i] = 0;
                end else begin
                    if (!m_s2[i]) begin
                        lr[i]++;
                        if (lr[i] == D) begin
                            armed[i] = 1; hr[i] = 0;
                        end
                    end else lr[i] = 0;
                end
            end
            if (vm_ready && q.size() > 0) m_money = q.pop_front();
            else m_money = 0;
            m_reject = (m_det[0] && m_det[1]) ? 1 : 0;
            if (m_det[0] ^ m_det[1]) begin
                if (q.size() < 4) q.push_back(m_det[0] ? 1 : 2);
                else m_overflow = 1;
            end
            m_s2[0] = m_s1[0]; m_s1[0] = coin_half;
            m_s2[1] = m_s1[1]; m_s1[1] = coin_dollar;
        end
    end

    int log_code [$];
    int log_cyc [$];
    int rej_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            check("money", 32'(money), 32'(m_money));
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("overflow", 32'(overflow), 32'(m_overflow));
            check("reject", 32'(reject), 32'(m_reject));
            if (money != 2'b00) begin
                log_code.push_back(int'(money));
                log_cyc.push_back(cyc);
            end
            if (reject) rej_cnt++;
        end
    end

    task automatic drive(input logic h, input logic d, input int n);
        coin_half = h;
        coin_dollar = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_code.delete();
        log_cyc.delete();
        rej_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    int tr;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_money", 32'(money), 0);
        check("rst_fifo", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_reject", 32'(reject), 0);
        rst = 1'b0;
        drive(0, 0, 8);

        // Single half coin: one 01 cycle, 2+D+1 edges from raw rise
        clear_log();
        tr = cyc + 1;
        drive(1, 0, 12);
        drive(0, 0, 10);
        check("half_n", 32'(log_code.size()), 1);
        if (log_code.size() == 1) begin
            check("half_code", 32'(log_code[0]), 1);
            check("half_latency", 32'(log_cyc[0] - tr), 6);
        end
        check("half_fifo", 32'(fifo_count), 0);

        // Dollar glitch of 3 cycles: nothing credited
        clear_log();
        drive(0, 1, 3);
        drive(0, 0, 8);
        check("glitch_n", 32'(log_code.size()), 0);
        check("glitch_rej", 32'(rej_cnt), 0);

        // Both sensors together: one reject pulse, no money
        clear_log();
        drive(1, 1, 8);
        drive(0, 0, 10);
        check("both_rej", 32'(rej_cnt), 1);
        check("both_n", 32'(log_code.size()), 0);
        check("both_fifo", 32'(fifo_count), 0);

        // Full FIFO with push and pop on the same edge
        clear_log();
        vm_ready = 1'b0;
        repeat (4) begin
            drive(0, 1, 6);
            drive(0, 0, 6);
        end
        check("full_fifo", 32'(fifo_count), 4);
        coin_half = 1'b1;
        tr = cyc + 1;
        while (cyc < tr + 4) @(negedge clk);
        vm_ready = 1'b1;
        @(negedge clk);
        check("pp_money", 32'(money), 2);
        check("pp_fifo", 32'(fifo_count), 4);
        check("pp_overflow", 32'(overflow), 0);
        drive(0, 0, 10);
        check("pp_n", 32'(log_code.size()), 5);
        if (log_code.size() == 5) begin
            for (int i = 0; i < 4; i++) check("pp_code", 32'(log_code[i]), 2);
            check("pp_last", 32'(log_code[4]), 1);
        end
        check("pp_drained", 32'(fifo_count), 0);

        // Five dollars while stalled: fifth dropped, sticky overflow
        clear_log();
        vm_ready = 1'b0;
        repeat (5) begin
            drive(0, 1, 6);
            drive(0, 0, 6);
        end
        check("ovf_fifo", 32'(fifo_count), 4);
        check("ovf_flag", 32'(overflow), 1);
        vm_ready = 1'b1;
        drive(0, 0, 8);
        check("ovf_n", 32'(log_code.size()), 4);
        if (log_code.size() == 4) begin
            for (int i = 0; i < 4; i++) check("ovf_code", 32'(log_code[i]), 2);
            for (int i = 0; i < 3; i++) check("ovf_b2b", 32'(log_cyc[i + 1] - log_cyc[i]), 1);
        end
        check("ovf_fifo0", 32'(fifo_count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Reset discards queued coins and a coin mid-confirmation
        rst = 1'b1;
        drive(0, 0, 2);
        rst = 1'b0;
        check("rst2_overflow", 32'(overflow), 0);
        drive(0, 0, 8);
        clear_log();
        vm_ready = 1'b0;
        repeat (2) begin
            drive(0, 1, 6);
            drive(0, 0, 6);
        end
        check("rst3_fifo_pre", 32'(fifo_count), 2);
        drive(0, 1, 4);
        rst = 1'b1;
        drive(0, 0, 2);
        rst = 1'b0;
        vm_ready = 1'b1;
        drive(0, 0, 12);
        check("rst3_n", 32'(log_code.size()), 0);
        check("rst3_fifo", 32'(fifo_count), 0);

        // Half, dollar, half with vm_ready toggling every cycle
        clear_log();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    vm_ready = (i % 2 == 0);
                    @(negedge clk);
                end
            end
            begin
                drive(1, 0, 6); drive(0, 0, 6);
                drive(0, 1, 6); drive(0, 0, 6);
                drive(1, 0, 6); drive(0, 0, 6);
            end
        join
        vm_ready = 1'b1;
        drive(0, 0, 5);
        check("tog_n", 32'(log_code.size()), 3);
        if (log_code.size() == 3) begin
            check("tog_0", 32'(log_code[0]), 1);
            check("tog_1", 32'(log_code[1]), 2);
            check("tog_2", 32'(log_code[2]), 1);
        end

        // Half held across reset: no coin until it has gone low and high again
        clear_log();
        drive(1, 0, 3);
        rst = 1'b1;
        drive(1, 0, 2);
        rst = 1'b0;
        drive(1, 0, 6);
        check("held_n", 32'(log_code.size()), 0);
        drive(0, 0, 5);
        drive(1, 0, 5);
        drive(0, 0, 8);
        check("rehalf_n", 32'(log_code.size()), 1);
        if (log_code.size() == 1) check("rehalf_code", 32'(log_code[0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
